// File: rtl/meas_uart_tx.sv
// meas_uart_tx: serialises a 42-character ASCII measurement report onto a UART line.
// Latency: TX drops to the first start bit on the edge START is accepted; a frame lasts 42*10*CLK_DIV cycles (42*11 with parity).
// Backpressure: none; a START seen while BUSY is dropped and latched in the sticky OVERRUN flag.
//
// Ports: CLK rising-edge clock, RSTB asynchronous active-high reset, START frame request,
//        frequency (6 BCD digits), max_t/min_t/mean_t/Vp2p_vol_t (5 BCD digits each),
//        TX serial line (idle high), BUSY frame in progress, DONE end-of-frame pulse,
//        OVERRUN sticky ignored-request flag.
// Build option: define MEAS_UART_PARITY_EN to insert an even-parity bit after the data bits.
module meas_uart_tx #(
    parameter int CLK_DIV = 434
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        START,
    input  logic [23:0] frequency,
    input  logic [19:0] max_t,
    input  logic [19:0] min_t,
    input  logic [19:0] mean_t,
    input  logic [19:0] Vp2p_vol_t,
    output logic        TX,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVERRUN
);

    localparam int              CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [5:0]      LAST_CHAR = 6'd41;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
`ifdef MEAS_UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [5:0]      char_idx;
    logic [7:0]      cur_char;

    logic [23:0]     snap_freq;
    logic [19:0]     snap_max;
    logic [19:0]     snap_min;
    logic [19:0]     snap_mean;
    logic [19:0]     snap_vpp;

    // Non-decimal nibbles are shown as '?' so corrupted BCD is visible on the terminal.
    function automatic logic [7:0] asc(input logic [3:0] n);
        return (n <= 4'd9) ? {4'h3, n} : 8'h3F;
    endfunction

    function automatic logic [39:0] dig5(input logic [19:0] v);
        return {asc(v[19:16]), asc(v[15:12]), asc(v[11:8]), asc(v[7:4]), asc(v[3:0])};
    endfunction

    // Whole report as one vector; character 0 sits in the top byte.
    logic [335:0] msg;
    logic [8:0]   byte_base;
    logic [7:0]   cur_byte;

    assign msg = {"F=", asc(snap_freq[23:20]), dig5(snap_freq[19:0]),
                  ",X=", dig5(snap_max),
                  ",N=", dig5(snap_min),
                  ",M=", dig5(snap_mean),
                  ",P=", dig5(snap_vpp),
                  8'h0D, 8'h0A};

    assign byte_base = {3'b000, LAST_CHAR - char_idx} << 3;
    assign cur_byte  = msg[byte_base +: 8];

    always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            char_idx  <= '0;
            cur_char  <= '0;
            snap_freq <= '0;
            snap_max  <= '0;
            snap_min  <= '0;
            snap_mean <= '0;
            snap_vpp  <= '0;
            TX        <= 1'b1;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            DONE <= 1'b0;

            // BUSY is still the pre-edge value here, so a START on the DONE edge counts as an overrun.
            if (START) begin
                OVERRUN <= BUSY;
            end

            case (state)
                IDLE: begin
                    if (START) begin
                        snap_freq <= frequency;
                        snap_max  <= max_t;
                        snap_min  <= min_t;
                        snap_mean <= mean_t;
                        snap_vpp  <= Vp2p_vol_t;
                        cnt       <= '0;
                        bit_idx   <= '0;
                        char_idx  <= '0;
                        BUSY      <= 1'b1;
                        TX        <= 1'b0;
                        state     <= START_BIT;
                    end
                end

                START_BIT: begin
                    if (cnt == CNT_LAST) begin
                        // Snapshot is stable by now, so the character is latched here.
                        cnt      <= '0;
                        cur_char <= cur_byte;
                        bit_idx  <= '0;
                        TX       <= cur_byte[0];
                        state    <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef MEAS_UART_PARITY_EN
                            TX    <= ^cur_char;
                            state <= PARITY;
`else
                            TX    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            TX      <= cur_char[bit_idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef MEAS_UART_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        TX    <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (char_idx == LAST_CHAR) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            TX    <= 1'b1;
                            state <= IDLE;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap.
                            char_idx <= char_idx + 1'b1;
                            TX       <= 1'b0;
                            state    <= START_BIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_meas_uart_tx.sv
`timescale 1ns/1ps
module tb_meas_uart_tx;

    localparam int DIV = 4;
`ifdef MEAS_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = 42 * NBITS * DIV;

    logic        CLK = 1'b0;
    logic        RSTB;
    logic        START;
    logic [23:0] frequency;
    logic [19:0] max_t, min_t, mean_t, Vp2p_vol_t;
    logic        TX, BUSY, DONE, OVERRUN;

    meas_uart_tx #(.CLK_DIV(DIV)) dut (
        .CLK        (CLK),
        .RSTB       (RSTB),
        .START      (START),
        .frequency  (frequency),
        .max_t      (max_t),
        .min_t      (min_t),
        .mean_t     (mean_t),
        .Vp2p_vol_t (Vp2p_vol_t),
        .TX         (TX),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    int done_cnt  = 0;
    int busy_cnt  = 0;
    int last_busy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the report text built straight from the field values.
    task automatic push_digits(input logic [23:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            int nib;
            nib = int'((v >> (4 * k)) & 24'hF);
            exp_q.push_back(nib < 10 ? 8'(48 + nib) : "?");
        end
    endtask

    task automatic push_frame(input logic [23:0] f, input logic [19:0] x, input logic [19:0] n,
                              input logic [19:0] m, input logic [19:0] p);
        exp_q.push_back("F"); exp_q.push_back("=");
        push_digits(f, 6);
        exp_q.push_back(","); exp_q.push_back("X"); exp_q.push_back("=");
        push_digits({4'h0, x}, 5);
        exp_q.push_back(","); exp_q.push_back("N"); exp_q.push_back("=");
        push_digits({4'h0, n}, 5);
        exp_q.push_back(","); exp_q.push_back("M"); exp_q.push_back("=");
        push_digits({4'h0, m}, 5);
        exp_q.push_back(","); exp_q.push_back("P"); exp_q.push_back("=");
        push_digits({4'h0, p}, 5);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    endtask

    function automatic int ones(input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    // UART receiver: samples each bit at its centre and checks against the scoreboard.
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    int         mon_b      = 0;
    logic [7:0] mon_rx     = 8'h00;
    logic [7:0] mon_exp    = 8'h00;
    logic       mon_par    = 1'b0;

    initial begin
        forever begin
            @(negedge CLK);
            if (RSTB === 1'b1) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (TX === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    mon_rx     = 8'h00;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt % DIV == DIV / 2) begin
                    mon_b = mon_cnt / DIV;
                    if (mon_b >= 1 && mon_b <= 8) begin
                        mon_rx[mon_b - 1] = TX;
                    end else if (mon_b == NBITS - 1) begin
                        check("stop_bit", 32'(TX), 32'd1);
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_char: got %0h expected nothing", mon_rx);
                        end else begin
                            mon_exp = exp_q.pop_front();
                            check("char", 32'(mon_rx), 32'(mon_exp));
`ifdef MEAS_UART_PARITY_EN
                            check("parity_bit", 32'(mon_par), 32'(ones(mon_exp) % 2));
`endif
                        end
                        mon_active = 1'b0;
                    end else if (mon_b == 9) begin
                        mon_par = TX;
                    end
                end
            end
        end
    end

    // BUSY run length and DONE pulse tracker.
    initial begin
        forever begin
            @(negedge CLK);
            if (RSTB === 1'b1) begin
                busy_cnt = 0;
            end else if (BUSY === 1'b1) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                last_busy = busy_cnt;
                busy_cnt  = 0;
            end
            if (DONE === 1'b1) done_cnt++;
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (DONE !== 1'b1 && n < 2 * FRAME) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2 * FRAME) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no DONE within %0d cycles, expected DONE", name, 2 * FRAME);
        end
    endtask

    task automatic set_inputs(input logic [23:0] f, input logic [19:0] x, input logic [19:0] n,
                              input logic [19:0] m, input logic [19:0] p);
        frequency = f; max_t = x; min_t = n; mean_t = m; Vp2p_vol_t = p;
    endtask

    task automatic scramble();
        set_inputs(24'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
    endtask

    // Called at a negedge: pulses START for one edge and checks the whole frame.
    task automatic run_frame(input string name, input logic [23:0] f, input logic [19:0] x,
                             input logic [19:0] n, input logic [19:0] m, input logic [19:0] p);
        int d0;
        d0 = done_cnt;
        set_inputs(f, x, n, m, p);
        START = 1'b1;
        push_frame(f, x, n, m, p);
        @(negedge CLK);
        START = 1'b0;
        check({name, "_busy_on_accept"}, 32'(BUSY), 32'd1);
        check({name, "_tx_start_bit"}, 32'(TX), 32'd0);
        check({name, "_overrun_cleared"}, 32'(OVERRUN), 32'd0);
        scramble();
        wait_done(name);
        @(negedge CLK);
        check({name, "_busy_len"}, 32'(last_busy), 32'(FRAME));
        check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_done_low_after"}, 32'(DONE), 32'd0);
        check({name, "_tx_idle"}, 32'(TX), 32'd1);
        check({name, "_chars_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        RSTB  = 1'b1;
        START = 1'b0;
        set_inputs('0, '0, '0, '0, '0);
        repeat (3) @(negedge CLK);
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_overrun", 32'(OVERRUN), 32'd0);

        // START on the very first edge after reset release.
        RSTB = 1'b0;
        run_frame("basic", 24'h001234, 20'h03300, 20'h00150, 20'h01725, 20'h03150);

        run_frame("bad_nibble", 24'h001234, 20'hA0000, 20'h00150, 20'h01725, 20'h03150);

        for (int i = 0; i < 3; i++) begin
            run_frame("random", 24'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
        end

        // Overrun: a second START mid-frame is ignored but flagged.
        d0 = done_cnt;
        set_inputs(24'h999999, 20'h12345, 20'h00000, 20'h55555, 20'h98765);
        push_frame(24'h999999, 20'h12345, 20'h00000, 20'h55555, 20'h98765);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (99) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("ovr_flag", 32'(OVERRUN), 32'd1);
        check("ovr_still_busy", 32'(BUSY), 32'd1);
        wait_done("ovr");
        @(negedge CLK);
        check("ovr_busy_len", 32'(last_busy), 32'(FRAME));
        check("ovr_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("ovr_sticky", 32'(OVERRUN), 32'd1);
        check("ovr_chars_left", 32'(exp_q.size()), 32'd0);
        run_frame("after_ovr", 24'h000001, 20'h00002, 20'h00003, 20'h00004, 20'h00005);

        // Reset in the middle of a frame aborts it at once.
        set_inputs(24'h314159, 20'h26535, 20'h89793, 20'h23846, 20'h26433);
        push_frame(24'h314159, 20'h26535, 20'h89793, 20'h23846, 20'h26433);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (499) @(negedge CLK);
        @(posedge CLK);
        #2;
        RSTB = 1'b1;
        #1;
        check("abort_tx", 32'(TX), 32'd1);
        check("abort_busy", 32'(BUSY), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        check("abort_overrun", 32'(OVERRUN), 32'd0);
        RSTB = 1'b0;
        run_frame("after_rst", 24'h271828, 20'h18284, 20'h59045, 20'h23536, 20'h02874);

        // START held high: two identical frames, one idle cycle apart.
        d0 = done_cnt;
        set_inputs(24'h000777, 20'h01010, 20'h09090, 20'h04321, 20'h00008);
        push_frame(24'h000777, 20'h01010, 20'h09090, 20'h04321, 20'h00008);
        push_frame(24'h000777, 20'h01010, 20'h09090, 20'h04321, 20'h00008);
        START = 1'b1;
        @(negedge CLK);
        check("b2b_first_tx", 32'(TX), 32'd0);
        wait_done("b2b_first");
        check("b2b_idle_tx", 32'(TX), 32'd1);
        check("b2b_idle_busy", 32'(BUSY), 32'd0);
        check("b2b_overrun", 32'(OVERRUN), 32'd1);
        @(negedge CLK);
        START = 1'b0;
        check("b2b_restart_busy", 32'(BUSY), 32'd1);
        check("b2b_restart_tx", 32'(TX), 32'd0);
        @(negedge CLK);
        wait_done("b2b_second");
        @(negedge CLK);
        check("b2b_busy_len", 32'(last_busy), 32'(FRAME));
        check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);
        check("b2b_chars_left", 32'(exp_q.size()), 32'd0);

        repeat (5) @(negedge CLK);
        check("final_tx_idle", 32'(TX), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
